// File: rtl/collector.sv
// collector: transposes filter-major convolution results into frame-major
// columns. Beats for filter 0 (frames 0..FRAME_LEN-1), then filter 1, and so
// on are written into a FRAME_LEN x (NUM_FILTERS*BW) register array. Once the
// last filter closes, the array is streamed out one column per cycle.
// Optional feature: define COLLECTOR_RELU_EN to clamp negative elements to 0
// before they are stored.
module collector #(
  parameter int BW          = 8,
  parameter int FRAME_LEN   = 50,
  parameter int NUM_FILTERS = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic signed [BW-1:0]               data_i,
  input  logic                               valid_i,
  input  logic                               last_i,
  output logic                               ready_o,
  output logic signed [NUM_FILTERS*BW-1:0]   data_o,
  output logic                               valid_o,
  output logic                               last_o,
  input  logic                               ready_i,
  output logic                               err_o
);

  localparam int FW = $clog2(FRAME_LEN);
  localparam int LW = $clog2(NUM_FILTERS);
  localparam int CW = NUM_FILTERS * BW;
  localparam logic [FW-1:0] LAST_FRAME  = FW'(FRAME_LEN - 1);
  localparam logic [LW-1:0] LAST_FILTER = LW'(NUM_FILTERS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [FW-1:0] frame_ctr;
  logic [LW-1:0] filter_ctr;
  logic [FW-1:0] rd_ptr;

  // Storage is intentionally left out of reset; slots skipped by an early
  // last_i keep whatever an earlier map left in them.
  logic [CW-1:0] mem [FRAME_LEN];

  logic          accept;
  logic          at_last_frame;
  logic          wrap;
  logic          close_map;
  logic          frame_err;
  logic [FW-1:0] rd_next;
  logic [CW-1:0] wr_col;

  // Element value as stored: clamped at zero when the ReLU build is selected.
  function automatic logic [BW-1:0] store_val(input logic [BW-1:0] d);
`ifdef COLLECTOR_RELU_EN
    store_val = d[BW-1] ? {BW{1'b0}} : d;
`else
    store_val = d;
`endif
  endfunction

  assign accept        = valid_i & ready_o;
  assign at_last_frame = (frame_ctr == LAST_FRAME);
  assign wrap          = last_i | at_last_frame;
  assign close_map     = wrap & (filter_ctr == LAST_FILTER);
  assign frame_err     = last_i ^ at_last_frame;
  assign rd_next       = rd_ptr + FW'(1);

  // Column currently addressed by frame_ctr with the incoming element merged
  // in; also forwarded to data_o when the closing beat lands in column 0.
  always_comb begin
    wr_col = mem[frame_ctr];
    wr_col[filter_ctr*BW +: BW] = store_val(data_i);
  end

  // Storage write for every accepted beat.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem[frame_ctr] <= wr_col;
    end
  end

  // Control FSM with registered handshake, data and error outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      frame_ctr  <= {FW{1'b0}};
      filter_ctr <= {LW{1'b0}};
      rd_ptr     <= {FW{1'b0}};
      ready_o    <= 1'b1;
      valid_o    <= 1'b0;
      last_o     <= 1'b0;
      err_o      <= 1'b0;
      data_o     <= {CW{1'b0}};
    end else begin
      case (state)
        IDLE, FILL: begin
          if (accept) begin
            if (frame_err) begin
              err_o <= 1'b1;
            end
            if (wrap) begin
              frame_ctr <= {FW{1'b0}};
              if (close_map) begin
                filter_ctr <= {LW{1'b0}};
                rd_ptr     <= {FW{1'b0}};
                state      <= DRAIN;
                ready_o    <= 1'b0;
                valid_o    <= 1'b1;
                last_o     <= 1'b0;
                data_o     <= (frame_ctr == {FW{1'b0}}) ? wr_col : mem[0];
              end else begin
                filter_ctr <= filter_ctr + LW'(1);
                state      <= FILL;
              end
            end else begin
              frame_ctr <= frame_ctr + FW'(1);
              state     <= FILL;
            end
          end
        end
        DRAIN: begin
          if (ready_i) begin
            if (rd_ptr == LAST_FRAME) begin
              state   <= IDLE;
              rd_ptr  <= {FW{1'b0}};
              ready_o <= 1'b1;
              valid_o <= 1'b0;
              last_o  <= 1'b0;
              data_o  <= {CW{1'b0}};
            end else begin
              rd_ptr <= rd_next;
              data_o <= mem[rd_next];
              last_o <= (rd_next == LAST_FRAME);
            end
          end
        end
        default: begin
          state      <= IDLE;
          frame_ctr  <= {FW{1'b0}};
          filter_ctr <= {LW{1'b0}};
          rd_ptr     <= {FW{1'b0}};
          ready_o    <= 1'b1;
          valid_o    <= 1'b0;
          last_o     <= 1'b0;
          data_o     <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collector.sv
// tb_collector: self-checking bench for collector with BW=8, FRAME_LEN=4,
// NUM_FILTERS=2. A map-level model tracks stored elements and the expected
// output stream; directed scenarios add literal column expectations.
module tb_collector;

  localparam int FL = 4;
  localparam int NF = 2;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        last_i;
  logic        ready_o;
  logic [15:0] data_o;
  logic        valid_o;
  logic        last_o;
  logic        ready_i;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  collector #(.BW(8), .FRAME_LEN(FL), .NUM_FILTERS(NF)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .data_i (data_i),
    .valid_i(valid_i),
    .last_i (last_i),
    .ready_o(ready_o),
    .data_o (data_o),
    .valid_o(valid_o),
    .last_o (last_o),
    .ready_i(ready_i),
    .err_o  (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] mdl    [FL][NF];
  bit         mknown [FL][NF];
  int         m_frame = 0;
  int         m_filter = 0;
  int         m_rd = 0;
  bit         m_drain = 1'b0;
  bit         m_err = 1'b0;

  initial begin
    for (int i = 0; i < FL; i++)
      for (int j = 0; j < NF; j++) begin
        mdl[i][j]    = 8'h00;
        mknown[i][j] = 1'b0;
      end
  end

  function automatic logic [7:0] m_relu(input logic [7:0] d);
`ifdef COLLECTOR_RELU_EN
    return d[7] ? 8'h00 : d;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a map is collected element by element, then streamed column-wise.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_frame  <= 0;
      m_filter <= 0;
      m_rd     <= 0;
      m_drain  <= 1'b0;
      m_err    <= 1'b0;
    end else if (!m_drain) begin
      if (valid_i) begin
        mdl[m_frame][m_filter]    <= m_relu(data_i);
        mknown[m_frame][m_filter] <= 1'b1;
        if (last_i != (m_frame == FL - 1)) m_err <= 1'b1;
        if (last_i || m_frame == FL - 1) begin
          m_frame <= 0;
          if (m_filter == NF - 1) begin
            m_filter <= 0;
            m_drain  <= 1'b1;
            m_rd     <= 0;
          end else begin
            m_filter <= m_filter + 1;
          end
        end else begin
          m_frame <= m_frame + 1;
        end
      end
    end else if (ready_i) begin
      if (m_rd == FL - 1) begin
        m_drain <= 1'b0;
        m_rd    <= 0;
      end else begin
        m_rd <= m_rd + 1;
      end
    end
  end

  // Compare all outputs against the model every cycle.
  always @(negedge clk) begin
    logic [15:0] ed;
    logic [15:0] em;
    chk("ready_o", {31'd0, ready_o}, {31'd0, !m_drain});
    chk("valid_o", {31'd0, valid_o}, {31'd0, m_drain});
    chk("last_o", {31'd0, last_o}, {31'd0, (m_drain && m_rd == FL - 1)});
    chk("err_o", {31'd0, err_o}, {31'd0, m_err});
    if (!m_drain) begin
      chk("data_idle", {16'd0, data_o}, 32'd0);
    end else begin
      ed = 16'h0000;
      em = 16'h0000;
      for (int f = 0; f < NF; f++) begin
        if (mknown[m_rd][f]) begin
          em[f*8 +: 8] = 8'hFF;
          ed[f*8 +: 8] = mdl[m_rd][f];
        end
      end
      chk("data_col", {16'd0, data_o & em}, {16'd0, ed});
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [15:0] exp_cols [FL];

  task automatic beat(input logic [7:0] d, input logic l);
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    @(negedge clk);
  endtask

  task automatic send_std(input logic [7:0] b, input bit hold);
    for (int k = 0; k < FL * NF; k++) begin
      beat(b + 8'(k), ((k % FL) == FL - 1));
    end
    if (!hold) begin
      valid_i = 1'b0;
      last_i  = 1'b0;
    end
  endtask

  task automatic drain_check(input int stall_col);
    for (int t = 0; t < 20 && valid_o !== 1'b1; t++) @(negedge clk);
    chk("drain_start", {31'd0, valid_o}, 32'd1);
    for (int c = 0; c < FL; c++) begin
      chk("col_data", {16'd0, data_o}, {16'd0, exp_cols[c]});
      chk("col_last", {31'd0, last_o}, {31'd0, (c == FL - 1)});
      chk("col_ready_o", {31'd0, ready_o}, 32'd0);
      if (c == stall_col) begin
        ready_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk("stall_data", {16'd0, data_o}, {16'd0, exp_cols[c]});
          chk("stall_valid", {31'd0, valid_o}, 32'd1);
          chk("stall_ready_o", {31'd0, ready_o}, 32'd0);
        end
        ready_i = 1'b1;
      end
      @(negedge clk);
    end
    chk("drain_end", {31'd0, valid_o}, 32'd0);
  endtask

  // ---------------- directed + random scenarios ----------------
  initial begin
    rst_n   = 1'b0;
    data_i  = 8'h00;
    valid_i = 1'b0;
    last_i  = 1'b0;
    ready_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_data", {16'd0, data_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic transpose
    send_std(8'h01, 1'b0);
    exp_cols[0] = 16'h0501; exp_cols[1] = 16'h0602;
    exp_cols[2] = 16'h0703; exp_cols[3] = 16'h0804;
    drain_check(-1);
    chk("basic_err", {31'd0, err_o}, 32'd0);

    // Backpressure on column 2 (index 1)
    send_std(8'h01, 1'b0);
    drain_check(1);

    // Early last on frame 2 of filter 0; frame 3 keeps the stale 0x04
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    beat(8'h03, 1'b1);
    valid_i = 1'b0;
    last_i  = 1'b0;
    chk("early_err", {31'd0, err_o}, 32'd1);
    beat(8'h09, 1'b0);
    beat(8'h0A, 1'b0);
    beat(8'h0B, 1'b0);
    beat(8'h0C, 1'b1);
    valid_i = 1'b0;
    last_i  = 1'b0;
    exp_cols[0] = 16'h0901; exp_cols[1] = 16'h0A02;
    exp_cols[2] = 16'h0B03; exp_cols[3] = 16'h0C04;
    drain_check(-1);

    // Reset mid-FILL after 3 beats
    beat(8'h41, 1'b0);
    beat(8'h42, 1'b0);
    beat(8'h43, 1'b0);
    valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, ready_o}, 32'd1);
    chk("arst_valid", {31'd0, valid_o}, 32'd0);
    chk("arst_data", {16'd0, data_o}, 32'd0);
    chk("arst_err", {31'd0, err_o}, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    send_std(8'h11, 1'b0);
    exp_cols[0] = 16'h1511; exp_cols[1] = 16'h1612;
    exp_cols[2] = 16'h1713; exp_cols[3] = 16'h1814;
    drain_check(-1);

    // ReLU on a negative element at filter 0, frame 0
    beat(8'hFB, 1'b0);
    beat(8'h02, 1'b0);
    beat(8'h03, 1'b0);
    beat(8'h04, 1'b1);
    beat(8'h05, 1'b0);
    beat(8'h06, 1'b0);
    beat(8'h07, 1'b0);
    beat(8'h08, 1'b1);
    valid_i = 1'b0;
    last_i  = 1'b0;
`ifdef COLLECTOR_RELU_EN
    exp_cols[0] = 16'h0500;
`else
    exp_cols[0] = 16'h05FB;
`endif
    exp_cols[1] = 16'h0602; exp_cols[2] = 16'h0703; exp_cols[3] = 16'h0804;
    drain_check(-1);

    // Back-to-back maps: valid_i held high through DRAIN
    send_std(8'h21, 1'b1);
    data_i = 8'h99;
    last_i = 1'b1;
    exp_cols[0] = 16'h2521; exp_cols[1] = 16'h2622;
    exp_cols[2] = 16'h2723; exp_cols[3] = 16'h2824;
    drain_check(-1);
    send_std(8'h31, 1'b0);
    exp_cols[0] = 16'h3531; exp_cols[1] = 16'h3632;
    exp_cols[2] = 16'h3733; exp_cols[3] = 16'h3834;
    drain_check(-1);

    // Random traffic with occasional framing errors and backpressure
    for (int cyc = 0; cyc < 600; cyc++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      data_i  = 8'($urandom);
      if (m_frame == FL - 1) last_i = ($urandom_range(0, 9) != 0);
      else                   last_i = ($urandom_range(0, 19) == 0);
      ready_i = ($urandom_range(0, 3) != 0);
      if (cyc == 300) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      @(negedge clk);
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
    ready_i = 1'b1;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
